// File: rtl/vote_pkg.sv
// Shared types, candidate codes and helpers for the jury voting session controller.
package vote_pkg;

    localparam int NUM_JURORS = 4;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DECIDE  = 2'd2,
        S_DONE    = 2'd3
    } vote_state_e;

    typedef logic [2:0] tally_t;

    localparam logic [1:0] CAND_A    = 2'b00;
    localparam logic [1:0] CAND_B    = 2'b01;
    localparam logic [1:0] CAND_C    = 2'b10;
    localparam logic [1:0] ABSTAIN   = 2'b11;
    localparam logic [1:0] NO_WINNER = 2'b11;

    function automatic logic [1:0] onehot_to_idx(input logic [NUM_JURORS-1:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < NUM_JURORS; i++) begin
            if (oh[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    // A candidate wins only with a strictly greater tally than both others;
    // this also makes an all-zero session a no-winner result.
    function automatic logic [1:0] decide_winner(input tally_t a, input tally_t b, input tally_t c);
        logic [1:0] w;
        w = NO_WINNER;
        if (a > b && a > c)      w = CAND_A;
        else if (b > a && b > c) w = CAND_B;
        else if (c > a && c > b) w = CAND_C;
        return w;
    endfunction

endpackage

// File: rtl/vote_session_ctrl_if.sv
// Juror-side handshake bundle: session start, per-juror requests/choices and one-hot acks.
interface vote_session_ctrl_if;
    import vote_pkg::*;

    logic                      start;
    logic [NUM_JURORS-1:0]     vote_req;
    logic [2*NUM_JURORS-1:0]   vote_val;
    logic [NUM_JURORS-1:0]     vote_ack;

    modport master (output start, vote_req, vote_val, input vote_ack);
    modport slave  (input start, vote_req, vote_val, output vote_ack);
endinterface

// File: rtl/rr_arbiter4.sv
// Combinational 4-way round-robin arbiter: first requester at or after ptr_i wins.
module rr_arbiter4 (
    input  logic [3:0] req_i,
    input  logic [1:0] ptr_i,
    output logic [3:0] grant_o,
    output logic       valid_o
);

    logic [7:0] req_dbl;
    logic [3:0] req_rot;
    logic [1:0] idx;

    // NOTE: every output and temporary gets a default at the top so no path
    // through the block leaves a value unassigned and infers a latch.
    always_comb begin
        req_dbl = {req_i, req_i} >> ptr_i;
        req_rot = req_dbl[3:0];
        valid_o = 1'b0;
        idx     = 2'd0;
        grant_o = 4'b0000;
        // Descending scan so the position closest to ptr_i is the one kept.
        for (int i = 3; i >= 0; i--) begin
            if (req_rot[i]) begin
                idx     = ptr_i + 2'(i);
                valid_o = 1'b1;
            end
        end
        if (valid_o) grant_o = 4'b0001 << idx;
    end

endmodule

// File: rtl/vote_session_ctrl.sv
// Jury voting session controller: accepts one vote per juror round-robin,
// closes on full turnout or timer expiry, then registers the winning candidate.
module vote_session_ctrl
    import vote_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    vote_session_ctrl_if.slave    bus,
    output logic [NUM_JURORS-1:0] voted_o,
    output tally_t                count_a_o,
    output tally_t                count_b_o,
    output tally_t                count_c_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [1:0]            winner_o,
    output logic                  timeout_o
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ST_IDLE    = S_IDLE;
    localparam logic [1:0] ST_COLLECT = S_COLLECT;
    localparam logic [1:0] ST_DECIDE  = S_DECIDE;
    localparam logic [1:0] ST_DONE    = S_DONE;

    logic [1:0]            state_q,   state_d;
    logic [1:0]            rr_ptr_q,  rr_ptr_d;
    logic [NUM_JURORS-1:0] voted_q,   voted_d;
    logic [NUM_JURORS-1:0] ack_q,     ack_d;
    tally_t                cnt_a_q,   cnt_a_d;
    tally_t                cnt_b_q,   cnt_b_d;
    tally_t                cnt_c_q,   cnt_c_d;
    logic                  done_q,    done_d;
    logic                  timeout_q, timeout_d;
    logic [1:0]            winner_q,  winner_d;
    logic [TW-1:0]         timer_q,   timer_d;

    logic [NUM_JURORS-1:0] pending;
    logic [NUM_JURORS-1:0] grant;
    logic                  grant_valid;
    logic [1:0]            grant_idx;
    logic [1:0]            grant_vote;

    assign pending    = bus.vote_req & ~voted_q;
    assign grant_idx  = onehot_to_idx(grant);
    assign grant_vote = bus.vote_val[{grant_idx, 1'b0} +: 2];

    rr_arbiter4 u_arb (
        .req_i   (pending),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant),
        .valid_o (grant_valid)
    );

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        voted_d   = voted_q;
        ack_d     = '0;
        cnt_a_d   = cnt_a_q;
        cnt_b_d   = cnt_b_q;
        cnt_c_d   = cnt_c_q;
        done_d    = 1'b0;
        timeout_d = timeout_q;
        winner_d  = winner_q;
        timer_d   = timer_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    voted_d   = '0;
                    cnt_a_d   = '0;
                    cnt_b_d   = '0;
                    cnt_c_d   = '0;
                    timeout_d = 1'b0;
                    timer_d   = '0;
                    state_d   = ST_COLLECT;
                end
            end

            ST_COLLECT: begin
                if (grant_valid) begin
                    voted_d  = voted_q | grant;
                    ack_d    = grant;
                    rr_ptr_d = grant_idx + 2'd1;
                    case (grant_vote)
                        CAND_A:  cnt_a_d = cnt_a_q + 3'd1;
                        CAND_B:  cnt_b_d = cnt_b_q + 3'd1;
                        CAND_C:  cnt_c_d = cnt_c_q + 3'd1;
                        default: ;
                    endcase
                end
                // Full turnout takes priority, so a session completing on the
                // last timer cycle is not reported as timed out.
                if (&voted_d) begin
                    state_d = ST_DECIDE;
                end else if (timer_q == TIMER_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = ST_DECIDE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            ST_DECIDE: begin
                winner_d = decide_winner(cnt_a_q, cnt_b_q, cnt_c_q);
                done_d   = 1'b1;
                state_d  = ST_DONE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= 2'd0;
            voted_q   <= '0;
            ack_q     <= '0;
            cnt_a_q   <= '0;
            cnt_b_q   <= '0;
            cnt_c_q   <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            winner_q  <= NO_WINNER;
            timer_q   <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            voted_q   <= voted_d;
            ack_q     <= ack_d;
            cnt_a_q   <= cnt_a_d;
            cnt_b_q   <= cnt_b_d;
            cnt_c_q   <= cnt_c_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            winner_q  <= winner_d;
            timer_q   <= timer_d;
        end
    end

    assign bus.vote_ack = ack_q;
    assign voted_o      = voted_q;
    assign count_a_o    = cnt_a_q;
    assign count_b_o    = cnt_b_q;
    assign count_c_o    = cnt_c_q;
    assign busy_o       = (state_q == ST_COLLECT) || (state_q == ST_DECIDE);
    assign done_o       = done_q;
    assign winner_o     = winner_q;
    assign timeout_o    = timeout_q;

endmodule

// File: doc/vote_session_ctrl.md
VOTE_SESSION_CTRL -- requirements
Module: vote_session_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum cycles spent in COLLECT before forced close.
REQ-002 clk  in  1  single system clock, rising-edge active.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 start  in  1  opens a session; sampled only in IDLE or DONE.
REQ-005 vote_req  in  4  per-juror request, bit k = juror k; held high until acked.
REQ-006 vote_val  in  8  juror k choice at [2k+1:2k]: 00=A, 01=B, 10=C, 11=abstain.
REQ-007 vote_ack  out  4  one-hot grant, high exactly one cycle per accepted vote.
REQ-008 voted  out  4  jurors already accepted this session.
REQ-009 count_a, count_b, count_c  out  3 each  per-candidate tallies, range 0..4.
REQ-010 busy  out  1  high in COLLECT and DECIDE.
REQ-011 done  out  1  one-cycle pulse on entry to DONE.
REQ-012 winner  out  2  00=A, 01=B, 10=C, 11=tie or no votes.
REQ-013 timeout  out  1  session closed by timer; held until next start.

Function
REQ-014 FSM states SHALL be IDLE, COLLECT, DECIDE, DONE.
REQ-015 start in IDLE/DONE SHALL clear counts, voted, timeout and timer, then enter COLLECT next edge; start in COLLECT/DECIDE SHALL be ignored.
REQ-016 In COLLECT, each edge SHALL accept at most one juror among vote_req & ~voted, chosen round-robin from pointer rr_ptr.
REQ-017 On acceptance of juror k, the same edge SHALL set voted[k], raise vote_ack[k] for the following cycle, increment the tally selected by vote_val[2k+1:2k], and set rr_ptr to (k+1) mod 4.
REQ-018 Abstain (11) SHALL set voted and ack without changing any tally.
REQ-019 Requests from jurors with voted set SHALL never be acked or counted.
REQ-020 vote_req and vote_val SHALL be ignored outside COLLECT.
REQ-021 COLLECT SHALL exit to DECIDE on the edge where voted becomes 1111, or when the timer reaches TIMEOUT_CYCLES-1, setting timeout=1; if both occur together, timeout SHALL stay 0.
REQ-022 DECIDE lasts one cycle and SHALL register winner as the candidate with strictly greatest tally; equal maxima or all-zero tallies SHALL give 11.
REQ-023 DONE SHALL hold counts, voted, winner and timeout stable until next start; done pulses only in the first DONE cycle.
REQ-024 Latency: with all four requests held from start, done SHALL be high in the 6th cycle after the start edge (4 accept edges, 1 DECIDE edge).
REQ-025 Tallies cannot exceed 4 by construction; 3-bit width SHALL be sufficient with no wrap.

Reset
REQ-026 rst SHALL immediately force IDLE, rr_ptr=0, counts=0, voted=0, vote_ack=0, busy=0, done=0, timeout=0, winner=11, timer=0.
REQ-027 rst asserted mid-session SHALL discard all partial tallies; no done pulse SHALL follow.

Structure
REQ-028 Shared package vote_pkg SHALL hold the state enum, candidate codes CAND_A/B/C, ABSTAIN=11 and NO_WINNER=11.
REQ-029 Round-robin selection SHALL be sub-module rr_arbiter4 (4-bit request, 2-bit pointer in; one-hot grant and valid out, combinational).

Verification
REQ-030 start; all jurors req with A,A,B,C -> acks 0001,0010,0100,1000 on consecutive cycles; counts 2/1/1; winner=00; done 6 cycles after start.
REQ-031 Votes B,B,C,C -> winner=11, timeout=0.
REQ-032 Only juror 2 requests (C), TIMEOUT_CYCLES=8 -> one ack, count_c=1, timeout=1, winner=10, done after timer expiry.
REQ-033 Juror 1 holds req after ack with new vote_val -> no second ack, count unchanged; start during COLLECT ignored.
REQ-034 All abstain -> counts 0/0/0, winner=11, voted=1111.
REQ-035 rst asserted after two accepts -> all outputs return to reset values immediately; next session begins from rr_ptr=0.
